// File: rtl/ps2_pkg.sv
// Shared types and scan-code constants for the PS/2 keyboard sequencer.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACK,
    ST_PARSE,
    ST_EMIT
  } state_t;

  localparam logic [7:0] SC_E0     = 8'hE0;
  localparam logic [7:0] SC_E1     = 8'hE1;
  localparam logic [7:0] SC_F0     = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_ALT    = 8'h11;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  localparam int CODE_W = 8;
  localparam int SKIP_W = 3;
  // Pause is E1 14 77 E1 F0 14 F0 77: seven bytes follow the leading E1.
  localparam logic [SKIP_W-1:0] PAUSE_TAIL = 3'd7;

  typedef struct packed {
    logic              valid;
    logic              ext;
    logic              brk;
    logic [CODE_W-1:0] code;
  } key_evt_t;

  function automatic logic is_ctrl_byte(input logic [7:0] b);
    return (b == 8'h00) || (b == 8'hAA) || (b == 8'hFA) ||
           (b == 8'hFE) || (b == 8'hFF);
  endfunction

endpackage

// File: rtl/ps2_kbd_ctrl_if.sv
// Receiver-FIFO pop handshake plus the valid/ready key-event channel.
interface ps2_kbd_ctrl_if;
  logic [7:0] kbd_data;
  logic       kbd_ready;
  logic       kbd_overflow;
  logic       kbd_nextdata_n;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;

  modport master (
    input  kbd_data, kbd_ready, kbd_overflow, evt_ready,
    output kbd_nextdata_n, evt_valid, evt_code, evt_ext, evt_break
  );

  modport slave (
    output kbd_data, kbd_ready, kbd_overflow, evt_ready,
    input  kbd_nextdata_n, evt_valid, evt_code, evt_ext, evt_break
  );
endinterface

// File: rtl/ps2_mod_tracker.sv
// Modifier (Shift/Ctrl/Alt) and CapsLock state, updated from parsed key events.
module ps2_mod_tracker
  import ps2_pkg::*;
(
  input  logic     clk,
  input  logic     clrn,
  input  key_evt_t upd,
  output logic     mod_shift,
  output logic     mod_ctrl,
  output logic     mod_alt,
  output logic     caps_lock
);

  logic lsh_q, rsh_q, lctrl_q, rctrl_q, lalt_q, ralt_q, caps_q, held_q;
  logic lsh_d, rsh_d, lctrl_d, rctrl_d, lalt_d, ralt_d, caps_d, held_d;
  logic make;

  always_comb begin
    lsh_d   = lsh_q;
    rsh_d   = rsh_q;
    lctrl_d = lctrl_q;
    rctrl_d = rctrl_q;
    lalt_d  = lalt_q;
    ralt_d  = ralt_q;
    caps_d  = caps_q;
    held_d  = held_q;
    make    = ~upd.brk;
    if (upd.valid) begin
      if (upd.code == SC_LSHIFT) lsh_d = make;
      if (upd.code == SC_RSHIFT) rsh_d = make;
      if (upd.code == SC_CTRL) begin
        if (upd.ext) rctrl_d = make;
        else         lctrl_d = make;
      end
      if (upd.code == SC_ALT) begin
        if (upd.ext) ralt_d = make;
        else         lalt_d = make;
      end
      // caps_held suppresses re-toggling on typematic repeats of CapsLock.
      if (upd.code == SC_CAPS) begin
        if (make) begin
          if (!held_q) caps_d = ~caps_q;
          held_d = 1'b1;
        end else begin
          held_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      lsh_q     <= 1'b0;
      rsh_q     <= 1'b0;
      lctrl_q   <= 1'b0;
      rctrl_q   <= 1'b0;
      lalt_q    <= 1'b0;
      ralt_q    <= 1'b0;
      caps_q    <= 1'b0;
      held_q    <= 1'b0;
      mod_shift <= 1'b0;
      mod_ctrl  <= 1'b0;
      mod_alt   <= 1'b0;
    end else begin
      lsh_q     <= lsh_d;
      rsh_q     <= rsh_d;
      lctrl_q   <= lctrl_d;
      rctrl_q   <= rctrl_d;
      lalt_q    <= lalt_d;
      ralt_q    <= ralt_d;
      caps_q    <= caps_d;
      held_q    <= held_d;
      mod_shift <= lsh_d | rsh_d;
      mod_ctrl  <= lctrl_d | rctrl_d;
      mod_alt   <= lalt_d | ralt_d;
    end
  end

  assign caps_lock = caps_q;

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 scan-code sequencer: pops receiver bytes, folds E0/F0/E1 prefixes into key events.
// Optional PS2_KBD_TYPEMATIC_FILTER_EN drops repeated makes of the last pressed key.
module ps2_kbd_ctrl
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int TO_W           = 20
) (
  input  logic           clk,
  input  logic           clrn,
  ps2_kbd_ctrl_if.master bus,
  output logic           mod_shift,
  output logic           mod_ctrl,
  output logic           mod_alt,
  output logic           caps_lock,
  output logic           err_ovf
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [7:0]        byte_q, byte_d;
  logic              nextdata_q, nextdata_d;
  logic              evt_valid_q, evt_valid_d;
  logic [7:0]        evt_code_q, evt_code_d;
  logic              evt_ext_q, evt_ext_d;
  logic              evt_brk_q, evt_brk_d;
  logic              ext_q, ext_d;
  logic              brk_q, brk_d;
  logic [SKIP_W-1:0] skip_q, skip_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic              ovf_q;
  logic              err_q, err_d;
  logic              emit;
  key_evt_t          trk_evt;
`ifdef PS2_KBD_TYPEMATIC_FILTER_EN
  logic [8:0]        last_make_q, last_make_d;
  logic              last_valid_q, last_valid_d;
`endif

  always_comb begin
    state_d     = state_q;
    byte_d      = byte_q;
    nextdata_d  = 1'b1;
    evt_valid_d = evt_valid_q;
    evt_code_d  = evt_code_q;
    evt_ext_d   = evt_ext_q;
    evt_brk_d   = evt_brk_q;
    ext_d       = ext_q;
    brk_d       = brk_q;
    skip_d      = skip_q;
    to_d        = to_q;
    err_d       = err_q;
    emit        = 1'b0;
    trk_evt     = '0;
`ifdef PS2_KBD_TYPEMATIC_FILTER_EN
    last_make_d  = last_make_q;
    last_valid_d = last_valid_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.kbd_ready) begin
          byte_d     = bus.kbd_data;
          nextdata_d = 1'b0;
          state_d    = ST_ACK;
        end else if (ext_q || brk_q) begin
          if (to_q == TO_LAST) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
            to_d  = '0;
          end else begin
            to_d = to_q + 1'b1;
          end
        end
      end
      ST_ACK: state_d = ST_PARSE;
      ST_PARSE: begin
        to_d    = '0;
        state_d = ST_IDLE;
        if (skip_q != '0) begin
          skip_d = skip_q - 1'b1;
        end else if (byte_q == SC_E1) begin
          skip_d = PAUSE_TAIL;
        end else if (byte_q == SC_E0) begin
          ext_d = 1'b1;
        end else if (byte_q == SC_F0) begin
          brk_d = 1'b1;
        end else if (is_ctrl_byte(byte_q)) begin
          ext_d = 1'b0;
          brk_d = 1'b0;
        end else begin
          trk_evt.valid = 1'b1;
          trk_evt.ext   = ext_q;
          trk_evt.brk   = brk_q;
          trk_evt.code  = byte_q;
`ifdef PS2_KBD_TYPEMATIC_FILTER_EN
          // A repeat of the last make is swallowed here; modifiers still see it.
          if (!brk_q && last_valid_q && (last_make_q == {ext_q, byte_q})) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
          end else begin
            if (brk_q) begin
              if (last_make_q == {ext_q, byte_q}) last_valid_d = 1'b0;
            end else begin
              last_make_d  = {ext_q, byte_q};
              last_valid_d = 1'b1;
            end
            emit = 1'b1;
          end
`else
          emit = 1'b1;
`endif
        end
      end
      ST_EMIT: begin
        if (bus.evt_ready) begin
          evt_valid_d = 1'b0;
          ext_d       = 1'b0;
          brk_d       = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (emit) begin
      evt_code_d  = byte_q;
      evt_ext_d   = ext_q;
      evt_brk_d   = brk_q;
      evt_valid_d = 1'b1;
      state_d     = ST_EMIT;
    end

    // An overflow means bytes were lost, so any partial prefix is meaningless.
    if (bus.kbd_overflow && !ovf_q) begin
      err_d  = 1'b1;
      ext_d  = 1'b0;
      brk_d  = 1'b0;
      skip_d = '0;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q     <= ST_IDLE;
      byte_q      <= '0;
      nextdata_q  <= 1'b1;
      evt_valid_q <= 1'b0;
      evt_code_q  <= '0;
      evt_ext_q   <= 1'b0;
      evt_brk_q   <= 1'b0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      skip_q      <= '0;
      to_q        <= '0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_q      <= byte_d;
      nextdata_q  <= nextdata_d;
      evt_valid_q <= evt_valid_d;
      evt_code_q  <= evt_code_d;
      evt_ext_q   <= evt_ext_d;
      evt_brk_q   <= evt_brk_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      skip_q      <= skip_d;
      to_q        <= to_d;
      ovf_q       <= bus.kbd_overflow;
      err_q       <= err_d;
    end
  end

`ifdef PS2_KBD_TYPEMATIC_FILTER_EN
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      last_make_q  <= '0;
      last_valid_q <= 1'b0;
    end else begin
      last_make_q  <= last_make_d;
      last_valid_q <= last_valid_d;
    end
  end
`endif

  ps2_mod_tracker u_mod_tracker (
    .clk       (clk),
    .clrn      (clrn),
    .upd       (trk_evt),
    .mod_shift (mod_shift),
    .mod_ctrl  (mod_ctrl),
    .mod_alt   (mod_alt),
    .caps_lock (caps_lock)
  );

  assign bus.kbd_nextdata_n = nextdata_q;
  assign bus.evt_valid      = evt_valid_q;
  assign bus.evt_code       = evt_code_q;
  assign bus.evt_ext        = evt_ext_q;
  assign bus.evt_break      = evt_brk_q;
  assign err_ovf            = err_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Directed scoreboard bench for ps2_kbd_ctrl with a byte-FIFO receiver model.
module tb_ps2_kbd_ctrl;
  import ps2_pkg::*;

  localparam int TO_CYC = 40;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } exp_t;

  logic clk = 1'b0;
  logic clrn;
  logic mod_shift, mod_ctrl, mod_alt, caps_lock, err_ovf;

  always #5 clk = ~clk;

  ps2_kbd_ctrl_if bus ();

  ps2_kbd_ctrl #(
    .TIMEOUT_CYCLES (TO_CYC),
    .TO_W           (8)
  ) dut (
    .clk       (clk),
    .clrn      (clrn),
    .bus       (bus),
    .mod_shift (mod_shift),
    .mod_ctrl  (mod_ctrl),
    .mod_alt   (mod_alt),
    .caps_lock (caps_lock),
    .err_ovf   (err_ovf)
  );

  logic [7:0] mem [0:255];
  logic [7:0] wr_ptr = '0;
  logic [7:0] rd_ptr = '0;
  int   evt_cnt = 0;
  int   pop_lows = 0;
  int   pop_pulses = 0;
  logic prev_n = 1'b1;

  int   tests = 0;
  int   fails = 0;
  int   base_evt, base_lows, base_pulses, unstable, n_exp, wait_n;
  exp_t sb[$];
  logic caps_exp[$];

  assign bus.kbd_ready = (rd_ptr != wr_ptr);
  assign bus.kbd_data  = mem[rd_ptr];

  // Receiver model: the FIFO head advances at the end of each low nextdata_n cycle.
  always @(posedge clk) begin
    if (bus.evt_valid && bus.evt_ready) evt_cnt <= evt_cnt + 1;
    if (!bus.kbd_nextdata_n) begin
      pop_lows <= pop_lows + 1;
      if (rd_ptr != wr_ptr) rd_ptr <= rd_ptr + 8'd1;
    end
    if (!bus.kbd_nextdata_n && prev_n) pop_pulses <= pop_pulses + 1;
    prev_n <= bus.kbd_nextdata_n;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic expect_evt(input logic [7:0] code, input logic ext, input logic brk);
    exp_t e;
    e.code = code;
    e.ext  = ext;
    e.brk  = brk;
    sb.push_back(e);
  endtask

  task automatic next_event();
    int   n = 0;
    exp_t e;
    while (!(bus.evt_valid && bus.evt_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!(bus.evt_valid && bus.evt_ready)) begin
      check_output("evt_timeout", 32'(bus.evt_valid), 32'd1);
      if (sb.size() != 0) e = sb.pop_front();
    end else if (sb.size() == 0) begin
      check_output("evt_unexpected", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check_output("evt_code", 32'(bus.evt_code), 32'(e.code));
      check_output("evt_ext", 32'(bus.evt_ext), 32'(e.ext));
      check_output("evt_break", 32'(bus.evt_break), 32'(e.brk));
    end
    @(negedge clk);
  endtask

  initial begin
    clrn             = 1'b0;
    bus.evt_ready    = 1'b1;
    bus.kbd_overflow = 1'b0;
    repeat (3) @(negedge clk);
    check_output("rst_nextdata_n", 32'(bus.kbd_nextdata_n), 32'd1);
    check_output("rst_evt_valid", 32'(bus.evt_valid), 32'd0);
    check_output("rst_evt_code", 32'(bus.evt_code), 32'd0);
    check_output("rst_evt_ext", 32'(bus.evt_ext), 32'd0);
    check_output("rst_evt_break", 32'(bus.evt_break), 32'd0);
    check_output("rst_mods", {29'd0, mod_shift, mod_ctrl, mod_alt}, 32'd0);
    check_output("rst_caps", 32'(caps_lock), 32'd0);
    check_output("rst_err_ovf", 32'(err_ovf), 32'd0);
    clrn = 1'b1;
    @(negedge clk);

    // Make then break of 1C: three single-cycle pops.
    base_lows   = pop_lows;
    base_pulses = pop_pulses;
    apply_stimulus(8'h1C); expect_evt(8'h1C, 1'b0, 1'b0);
    apply_stimulus(8'hF0);
    apply_stimulus(8'h1C); expect_evt(8'h1C, 1'b0, 1'b1);
    next_event();
    next_event();
    repeat (5) @(negedge clk);
    check_output("pop_pulses", 32'(pop_pulses - base_pulses), 32'd3);
    check_output("pop_low_cycles", 32'(pop_lows - base_lows), 32'd3);

    // Extended break folds into one event.
    base_evt = evt_cnt;
    apply_stimulus(8'hE0);
    apply_stimulus(8'hF0);
    apply_stimulus(8'h75); expect_evt(8'h75, 1'b1, 1'b1);
    next_event();
    repeat (10) @(negedge clk);
    check_output("e0f0_evt_count", 32'(evt_cnt - base_evt), 32'd1);

    // Shift held across another key.
    apply_stimulus(8'h12); expect_evt(8'h12, 1'b0, 1'b0);
    apply_stimulus(8'h1C); expect_evt(8'h1C, 1'b0, 1'b0);
    apply_stimulus(8'hF0);
    apply_stimulus(8'h12); expect_evt(8'h12, 1'b0, 1'b1);
    next_event();
    check_output("shift_after_make", 32'(mod_shift), 32'd1);
    next_event();
    check_output("shift_during_1c", 32'(mod_shift), 32'd1);
    next_event();
    check_output("shift_after_break", 32'(mod_shift), 32'd0);

    // CapsLock with typematic repeats.
    base_evt = evt_cnt;
    apply_stimulus(8'h58);
    apply_stimulus(8'h58);
    apply_stimulus(8'h58);
    apply_stimulus(8'hF0);
    apply_stimulus(8'h58);
    apply_stimulus(8'h58);
`ifdef PS2_KBD_TYPEMATIC_FILTER_EN
    expect_evt(8'h58, 1'b0, 1'b0); caps_exp.push_back(1'b1);
    expect_evt(8'h58, 1'b0, 1'b1); caps_exp.push_back(1'b1);
    expect_evt(8'h58, 1'b0, 1'b0); caps_exp.push_back(1'b0);
`else
    expect_evt(8'h58, 1'b0, 1'b0); caps_exp.push_back(1'b1);
    expect_evt(8'h58, 1'b0, 1'b0); caps_exp.push_back(1'b1);
    expect_evt(8'h58, 1'b0, 1'b0); caps_exp.push_back(1'b1);
    expect_evt(8'h58, 1'b0, 1'b1); caps_exp.push_back(1'b1);
    expect_evt(8'h58, 1'b0, 1'b0); caps_exp.push_back(1'b0);
`endif
    n_exp = caps_exp.size();
    for (int i = 0; i < n_exp; i++) begin
      next_event();
      check_output("caps_lock", 32'(caps_lock), 32'(caps_exp.pop_front()));
    end
    repeat (10) @(negedge clk);
    check_output("caps_evt_count", 32'(evt_cnt - base_evt), 32'(n_exp));

    // Pause sequence is swallowed; only the trailing 1C is reported.
    base_evt = evt_cnt;
    foreach (mem[i]) if (i < 0) mem[i] = 8'h00;
    apply_stimulus(8'hE1);
    apply_stimulus(8'h14);
    apply_stimulus(8'h77);
    apply_stimulus(8'hE1);
    apply_stimulus(8'hF0);
    apply_stimulus(8'h14);
    apply_stimulus(8'hF0);
    apply_stimulus(8'h77);
    apply_stimulus(8'h1C); expect_evt(8'h1C, 1'b0, 1'b0);
    next_event();
    repeat (5) @(negedge clk);
    check_output("pause_evt_count", 32'(evt_cnt - base_evt), 32'd1);
    check_output("pause_no_ctrl", 32'(mod_ctrl), 32'd0);

    // A stale E0 prefix times out.
    apply_stimulus(8'hE0);
    repeat (TO_CYC + 10) @(negedge clk);
    apply_stimulus(8'h1D); expect_evt(8'h1D, 1'b0, 1'b0);
    next_event();

    // Backpressure: event held, no further pops.
    bus.evt_ready = 1'b0;
    base_pulses   = pop_pulses;
    apply_stimulus(8'h2A); expect_evt(8'h2A, 1'b0, 1'b0);
    apply_stimulus(8'h2B); expect_evt(8'h2B, 1'b0, 1'b0);
    apply_stimulus(8'h2C); expect_evt(8'h2C, 1'b0, 1'b0);
    wait_n = 0;
    while (!bus.evt_valid && wait_n < 50) begin
      @(negedge clk);
      wait_n++;
    end
    check_output("hold_valid", 32'(bus.evt_valid), 32'd1);
    unstable = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!(bus.evt_valid && bus.evt_code == 8'h2A && !bus.evt_ext && !bus.evt_break))
        unstable++;
    end
    check_output("hold_unstable_cycles", 32'(unstable), 32'd0);
    check_output("hold_pops", 32'(pop_pulses - base_pulses), 32'd1);
    bus.evt_ready = 1'b1;
    next_event();
    next_event();
    next_event();

    // Overflow is sticky and discards a pending F0.
    apply_stimulus(8'hF0);
    repeat (10) @(negedge clk);
    bus.kbd_overflow = 1'b1;
    @(negedge clk);
    bus.kbd_overflow = 1'b0;
    repeat (2) @(negedge clk);
    check_output("err_ovf_set", 32'(err_ovf), 32'd1);
    apply_stimulus(8'h3A); expect_evt(8'h3A, 1'b0, 1'b0);
    next_event();
    repeat (20) @(negedge clk);
    check_output("err_ovf_sticky", 32'(err_ovf), 32'd1);

    clrn = 1'b0;
    #1;
    check_output("clrn_err_ovf", 32'(err_ovf), 32'd0);
    check_output("clrn_evt_valid", 32'(bus.evt_valid), 32'd0);
    check_output("clrn_nextdata_n", 32'(bus.kbd_nextdata_n), 32'd1);
    check_output("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
